// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot,
// guard-band blanking between digit slots and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 1,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]       div_cnt;
  logic [1:0]          idx;
  logic [15:0]         data_sh;
  logic [3:0]          dp_sh;
  logic [3:0][7:0]     dig_lit;   // active-high {dp, g..a} per digit
  logic                div_wrap, snap, guard;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  assign div_wrap = (div_cnt == CW'(SCAN_DIV - 1));
  assign snap     = (idx == 2'd0) && (div_cnt == '0);
  assign guard    = (div_cnt < CW'(GUARD));

  // Digit k is a leading zero when it and every digit above it are zero.
  for (genvar k = 0; k < 4; k++) begin : g_dig
    logic blank;
    if (k == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = BLANK_LZ && (data_sh[15:4*k] == '0);
    end
    assign dig_lit[k] = {dp_sh[k], blank ? 7'h00 : hex7(data_sh[4*k +: 4])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
      data_sh <= '0;
      dp_sh   <= '0;
      sel     <= 4'hF;
      seg     <= 8'hFF;
      frame   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) idx <= idx + 2'd1;
      if (snap) begin
        data_sh <= data;
        dp_sh   <= dp_mask;
      end
      frame <= snap;
      // Guard cycles cover the snapshot edge, so lit digits always see fresh shadow.
      if (guard) begin
        sel <= 4'hF;
        seg <= 8'hFF;
      end else begin
        sel <= ~(4'b0001 << idx);
        seg <= ~dig_lit[idx];
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: frame scan order, snapshot isolation,
// decimal points, leading-zero blanking, mid-scan reset and scan-timing monitor.
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic        frame_a, frame_b, frame_c;
  logic [3:0]  m_sel;
  logic [7:0]  m_seg;
  logic        m_frame;
  int          which;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(1'b0)) u_dut (
    .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask),
    .sel(sel_a), .seg(seg_a), .frame(frame_a));
  seg_scan_driver #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(1'b1)) u_lz (
    .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask),
    .sel(sel_b), .seg(seg_b), .frame(frame_b));
  seg_scan_driver #(.SCAN_DIV(5), .GUARD(2), .BLANK_LZ(1'b0)) u_w (
    .clk(clk), .rst(rst), .data(data), .dp_mask(dp_mask),
    .sel(sel_c), .seg(seg_c), .frame(frame_c));

  always_comb begin
    m_sel = sel_a; m_seg = seg_a; m_frame = frame_a;
    case (which)
      1: begin m_sel = sel_b; m_seg = seg_b; m_frame = frame_b; end
      2: begin m_sel = sel_c; m_seg = seg_c; m_frame = frame_c; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 16-cycle frame for a SCAN_DIV=4/GUARD=1 instance, starting at the snapshot.
  task automatic check_frame(input int w, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input bit chg, input logic [15:0] nd, input string tag);
    logic [7:0] e[4];
    logic [3:0] es;
    e = '{e0, e1, e2, e3};
    which = w;
    for (int i = 0; i < 16; i++) begin
      step();
      es = 4'b0001 << (i / 4);
      es = ~es;
      chk($sformatf("%s_frame%0d", tag, i), {31'd0, m_frame}, {31'd0, (i == 0)});
      chk($sformatf("%s_sel%0d", tag, i), {28'd0, m_sel}, (i % 4 == 0) ? 32'hF : {28'd0, es});
      chk($sformatf("%s_seg%0d", tag, i), {24'd0, m_seg}, (i % 4 == 0) ? 32'hFF : {24'd0, e[i/4]});
      if (chg && i == 8) data = nd;
    end
  endtask

  task automatic long_run(input int w, input int ncyc, input int period, input int lit);
    int last_f, run, viol;
    bit seen_dark;
    last_f = -1; run = 0; viol = 0; seen_dark = 1'b0;
    which = w;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (m_frame) begin
        if (last_f >= 0) chk($sformatf("spacing_w%0d", w), i - last_f, period);
        last_f = i;
      end
      if ($countones(~m_sel) > 1) viol++;
      if (m_sel == 4'hF) begin
        if (run > 0 && seen_dark) chk($sformatf("lit_len_w%0d", w), run, lit);
        seen_dark = 1'b1;
        run = 0;
      end else begin
        run++;
      end
    end
    chk($sformatf("onehot_w%0d", w), viol, 0);
    chk($sformatf("saw_frame_w%0d", w), {31'd0, (last_f >= 0)}, 32'd1);
  endtask

  initial begin
    which = 0; rst = 1'b1; data = 16'h1234; dp_mask = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sel", {28'd0, sel_a}, 32'hF);
      chk("rst_seg", {24'd0, seg_a}, 32'hFF);
      chk("rst_frame", {31'd0, frame_a}, 32'd0);
    end
    rst = 1'b0;
    check_frame(0, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0, 16'h0, "f1234");
    check_frame(0, 8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b1, 16'hABCD, "isolate");
    check_frame(0, 8'hA1, 8'hC6, 8'h83, 8'h88, 1'b0, 16'h0, "fabcd");
    data = 16'h8888; dp_mask = 4'b0101;
    check_frame(0, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 16'h0, "dp");
    data = 16'h0070; dp_mask = 4'b0000;
    check_frame(1, 8'hC0, 8'hF8, 8'hFF, 8'hFF, 1'b0, 16'h0, "lz70");
    data = 16'h0000;
    check_frame(1, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 16'h0, "lz0");
    dp_mask = 4'b1000;
    check_frame(1, 8'hC0, 8'hFF, 8'hFF, 8'h7F, 1'b0, 16'h0, "lzdp");
    dp_mask = 4'b0000;
    check_frame(0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0, 16'h0, "zero");

    // Counter now at idx=2, div_cnt=3 after 11 cycles.
    for (int i = 0; i < 11; i++) step();
    rst = 1'b1;
    step();
    chk("mid_rst_sel", {28'd0, sel_a}, 32'hF);
    chk("mid_rst_seg", {24'd0, seg_a}, 32'hFF);
    chk("mid_rst_frame", {31'd0, frame_a}, 32'd0);
    step();
    rst = 1'b0; data = 16'h0F00;
    check_frame(0, 8'hC0, 8'hC0, 8'h8E, 8'hC0, 1'b0, 16'h0, "restart");

    long_run(0, 160, 16, 3);
    long_run(2, 200, 20, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Four-digit multiplexed seven-segment scanner for the board display path. It consumes the 16-bit halfword selected for display (upper or lower half of the memory word under inspection) and drives the shared `sel`/`seg` pins. It generates its own digit-scan timing from the system clock with a clock-enable counter, so no divided clock is needed. Input data is snapshotted once per scan frame, so a word never appears half-updated.

## Interface
- `SCAN_DIV`, 50000: clk cycles per digit slot; legal range ≥ 2.
- `GUARD`, 1: cycles at the start of each slot with all digits off (anti-ghosting); legal range 1 ≤ GUARD < SCAN_DIV.
- `BLANK_LZ`, 0: 1 = blank leading zero digits.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `data`  in  16  value to show; nibble k goes to digit k, with digit 0 rightmost.
- `dp_mask`  in  4  bit k lights the decimal point of digit k.
- `sel`  out  4  digit enables, active-low, one-hot-low while lit.
- `seg`  out  8  segments, active-low; bit 0 = a … bit 6 = g, bit 7 = dp.
- `frame`  out  1  one-cycle pulse marking the cycle after a snapshot.

## Operation
- `div_cnt` runs 0..SCAN_DIV-1 and wraps. On wrap, `idx` (2 bits) increments, going 0→1→2→3→0.
- Snapshot rule: in any cycle with `idx==0 && div_cnt==0`, the block loads `{dp_mask,data}` into shadow registers and registers `frame<=1`. In all other cycles it registers `frame<=0`.
  - Input changes at any other time are ignored until the next frame start.
- Output register update each cycle:
  - If `div_cnt < GUARD`: `sel<=4'b1111`, `seg<=8'hFF`.
  - Otherwise: `sel<=~(4'b0001<<idx)`, `seg<=~{dp_shadow[idx], hex(nib)}`, where `nib = data_shadow[4*idx+3:4*idx]`.
  - `sel`/`seg` are computed from the shadow value loaded at the same edge as `div_cnt==0`. GUARD ≥ 1 guarantees a lit digit always uses the current frame's snapshot.
- Hex decode (lit segments):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
- Leading-zero blank (BLANK_LZ=1 only):
  - Digit k ∈ {3,2,1} is blank (segments a–g off) when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - The dp bit is unaffected by blanking.
  - `sel` still asserts for blanked digits, so slot timing is unchanged.
- No handshake on inputs. `data`/`dp_mask` must be stable in the snapshot cycle; the upstream address stepper changes far slower than a frame.

## Timing
- Reset (any cycle `rst==1`, including mid-scan): `div_cnt=0`, `idx=0`, shadow=0, `sel=4'b1111`, `seg=8'hFF`, `frame=0`, all on the next edge.
- The first cycle with `rst==0` is a snapshot cycle, so `frame` is high in the second cycle after reset release.
- Frame period is 4·SCAN_DIV cycles. `frame` is high exactly once per period, for 1 cycle.
- Output latency is 1 cycle: `sel`/`seg` reflect the (`idx`,`div_cnt`) of the previous cycle.
- Each digit is lit for SCAN_DIV−GUARD cycles, followed by GUARD dark cycles before the next digit.
- At most one `sel` bit is low in any cycle, never two, including across the `idx` wrap.
- Data change latency to display is at most 4·SCAN_DIV+1 cycles.

## Test plan
All scenarios use SCAN_DIV=4, GUARD=1 unless noted.
- Reset/first frame: hold rst 3 cycles, release with data=16'h1234, dp_mask=0.
  - Required: `sel`=F, `seg`=FF during reset; `frame` pulses in cycle 2 after release.
  - Then, per frame, `sel` cycles through dark,E,E,E, dark,D,D,D, dark,B,B,B, dark,7,7,7.
  - `seg` shows ~{0,"4"}=8'h99 with sel=E, 8'hB0 ("3") with sel=D, 8'hA4 with sel=B, 8'hF9 with sel=7.
- Snapshot isolation: change data 16'h1234→16'hABCD mid-frame (idx=2).
  - Required: digits 2,3 still show 3,4-frame values 2 and 1 until the next `frame`; the next frame shows D,C,B,A (8'hA1, 8'hC6, 8'h83, 8'h88).
- Decimal points: dp_mask=4'b0101, data=16'h8888.
  - Required: `seg`=8'h00 on digits 0 and 2, 8'h80 on digits 1 and 3.
- Leading-zero blank: BLANK_LZ=1, data=16'h0070.
  - Required: digits 3 and 2 show `seg`=FF with `sel` asserted, digit 1 shows 8'hF8, digit 0 shows 8'hC0.
  - data=0: digits 3..1 blank, digit 0 shows 8'hC0.
- Reset mid-operation: assert rst at idx=2, div_cnt=3.
  - Required: next edge gives `sel`=F, `seg`=FF, `frame`=0; after release the scan restarts at digit 0 with a fresh snapshot.
- Long-run check with SCAN_DIV=50000: over 10 frames, `frame` spacing is 200000 cycles, no cycle has more than one `sel` bit low, and each digit is lit for 49999 cycles.
